// File: rtl/miyajiro_pkg.sv
// Shared types for the program loader: load/receiver state encodings,
// the debug state bundle and the default baud divisor.
package miyajiro_pkg;

    // 100 MHz system clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERROR   = 2'd3
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef struct packed {
        load_state_t load;
        rx_state_t   rx;
    } dbg_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 bit-level receiver with a 2-flop input synchronizer.
// byte_valid / frame_err are one-cycle strobes with no backpressure: the consumer samples them the cycle they are high.
module uart_rx
    import miyajiro_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output rx_state_t  dbg_state
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       r_sync;
    logic             r_rx_prev;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             w_rx;

    assign w_rx      = r_sync[1];
    assign dbg_state = r_state;

    // Synchronizer and edge history reset high so reset release never looks like a start bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync     <= 2'b11;
            r_rx_prev  <= 1'b1;
            r_state    <= RX_IDLE;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], rx_in};
            r_rx_prev  <= w_rx;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (r_rx_prev && !w_rx) r_state <= RX_START;
                end
                RX_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        r_state   <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= '0;
                        r_state   <= RX_IDLE;
                        if (w_rx) begin
                            byte_valid <= 1'b1;
                            byte_data  <= r_shift;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian word stream from UART into
// instruction memory, then releases the CPU.
module program_loader
    import miyajiro_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_start,
    output logic              load_error,
    output dbg_state_t        dbg_state
);

    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

    logic [7:0]        w_byte_data;
    logic              w_byte_valid;
    logic              w_frame_err;
    rx_state_t         w_rx_state;
    logic [31:0]       w_word;
    logic              w_last;

    load_state_t       r_state;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_asm;
    logic [31:0]       r_count;
    logic [ADDR_W-1:0] r_word_idx;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx_in      (uart_rx),
        .byte_data  (w_byte_data),
        .byte_valid (w_byte_valid),
        .frame_err  (w_frame_err),
        .dbg_state  (w_rx_state)
    );

    // r_asm holds the three earlier bytes of the word, oldest in the low byte
    assign w_word    = {w_byte_data, r_asm};
    assign w_last    = (32'(r_word_idx) == r_count - 32'd1);
    assign dbg_state = '{load: r_state, rx: w_rx_state};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_HEADER;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_count    <= '0;
            r_word_idx <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_start  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (r_state)
                ST_HEADER: begin
                    if (w_frame_err) begin
                        r_state    <= ST_ERROR;
                        load_error <= 1'b1;
                    end else if (w_byte_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_asm      <= {w_byte_data, r_asm[23:8]};
                        if (r_byte_cnt == 2'd3) begin
                            r_count    <= w_word;
                            r_word_idx <= '0;
                            if (w_word == 32'd0) begin
                                r_state <= ST_DONE;
                            end else if ({1'b0, w_word} > MAX_WORDS) begin
                                r_state    <= ST_ERROR;
                                load_error <= 1'b1;
                            end else begin
                                r_state <= ST_PAYLOAD;
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_frame_err) begin
                        r_state    <= ST_ERROR;
                        load_error <= 1'b1;
                    end else if (w_byte_valid) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_asm      <= {w_byte_data, r_asm[23:8]};
                        if (r_byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= r_word_idx;
                            imem_wdata <= w_word;
                            r_word_idx <= r_word_idx + 1'b1;
                            if (w_last) r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE:  cpu_start  <= 1'b1;
                ST_ERROR: load_error <= 1'b1;
                default:  r_state    <= ST_ERROR;
            endcase
        end
    end

endmodule
